// File: rtl/button_counter_if.sv
// Board-side signals of button_counter: raw active-low button in, active-low LED
// bank and press strobe out. The DUT takes the slave modport.
interface button_counter_if;
   logic       button1;
   logic [5:0] led;
   logic       press_pulse;

   modport master (output button1, input led, input press_pulse);
   modport slave  (input button1, output led, output press_pulse);
endinterface

// File: rtl/button_counter.sv
// Synchronises and debounces button1, counts accepted presses and drives active-low LEDs.
// Optional hold-to-repeat is enabled by defining BUTTON_AUTOREPEAT_EN.
module button_counter #(
   parameter int DEBOUNCE_CYCLES = 270000,
   parameter int REPEAT_DELAY    = 13500000,
   parameter int REPEAT_PERIOD   = 2700000
) (
   input logic              clk,
   input logic              rst_n,
   button_counter_if.slave  bus
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] IDLE         = 2'd0;
   localparam logic [1:0] PRESS_WAIT   = 2'd1;
   localparam logic [1:0] PRESSED      = 2'd2;
   localparam logic [1:0] RELEASE_WAIT = 2'd3;

   logic            sync1, sync0;
   logic            btn_s;
   logic [1:0]      state;
   logic [DB_W-1:0] db_cnt;
   logic [5:0]      count;
   logic            pulse_q;

   // Two-flop synchroniser; resets to the released (high) level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         sync0 <= 1'b1;
      end else begin
         sync1 <= bus.button1;
         sync0 <= sync1;
      end
   end

   assign btn_s = ~sync0;

`ifdef BUTTON_AUTOREPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);

   logic [RPT_W-1:0] rpt_cnt;
   logic [RPT_W-1:0] rpt_lim;
   logic             rpt_first;

   // First repeat waits the long delay, later ones the short period.
   assign rpt_lim = rpt_first ? RPT_W'(REPEAT_DELAY - 1) : RPT_W'(REPEAT_PERIOD - 1);
`else
   localparam int unused_rpt = REPEAT_DELAY + REPEAT_PERIOD;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         db_cnt  <= '0;
         count   <= '0;
         pulse_q <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
         rpt_cnt   <= '0;
         rpt_first <= 1'b1;
`endif
      end else begin
         pulse_q <= 1'b0;
         case (state)
            IDLE: begin
               db_cnt <= '0;
               if (btn_s) state <= PRESS_WAIT;
            end
            PRESS_WAIT: begin
               if (!btn_s) begin
                  state  <= IDLE;
                  db_cnt <= '0;
               end else if (db_cnt == DB_LAST) begin
                  state   <= PRESSED;
                  db_cnt  <= '0;
                  pulse_q <= 1'b1;
                  count   <= count + 6'd1;
`ifdef BUTTON_AUTOREPEAT_EN
                  rpt_cnt   <= '0;
                  rpt_first <= 1'b1;
`endif
               end else begin
                  db_cnt <= db_cnt + 1'b1;
               end
            end
            PRESSED: begin
               // Release wins over a coincident repeat; the timer freezes in RELEASE_WAIT.
               if (!btn_s) begin
                  state  <= RELEASE_WAIT;
                  db_cnt <= '0;
               end
`ifdef BUTTON_AUTOREPEAT_EN
               else if (rpt_cnt == rpt_lim) begin
                  pulse_q   <= 1'b1;
                  count     <= count + 6'd1;
                  rpt_cnt   <= '0;
                  rpt_first <= 1'b0;
               end else begin
                  rpt_cnt <= rpt_cnt + 1'b1;
               end
`endif
            end
            RELEASE_WAIT: begin
               if (btn_s) begin
                  state  <= PRESSED;
                  db_cnt <= '0;
               end else if (db_cnt == DB_LAST) begin
                  state  <= IDLE;
                  db_cnt <= '0;
               end else begin
                  db_cnt <= db_cnt + 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               db_cnt <= '0;
            end
         endcase
      end
   end

   assign bus.led         = ~count;
   assign bus.press_pulse = pulse_q;

endmodule

// File: tb/tb_button_counter.sv
// Directed bench for button_counter with short debounce/repeat parameters.
// Expected pulse timing: button edge driven after edge c0 -> pulse seen at cycle c0+7.
module tb_button_counter;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;
   int   pt[256];
   int   pt_n = 0;
   int   dbl = 0;
   logic prev_pulse = 1'b0;
   int   base, c0;

   button_counter_if bus();

   button_counter #(
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY   (20),
      .REPEAT_PERIOD  (8)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse log: cycle of each strobe, plus count of back-to-back strobes.
   always @(negedge clk) begin
      if (bus.press_pulse === 1'b1) begin
         if (pt_n < 256) pt[pt_n] <= cyc;
         pt_n <= pt_n + 1;
         if (prev_pulse) dbl <= dbl + 1;
      end
      prev_pulse <= bus.press_pulse;
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic lvl, input int n);
      bus.button1 = lvl;
      step(n);
   endtask

`ifdef BUTTON_AUTOREPEAT_EN
   int rep_off[6] = '{0, 20, 28, 36, 44, 52};
`endif

   initial begin
      bus.button1 = 1'b1;
      rst_n = 1'b0;
      step(1);

      // reset held while the button toggles
      for (int i = 0; i < 8; i++) begin
         bus.button1 = (i % 2 == 0);
         step(1);
         chk("rst_led", bus.led, 63);
         chk("rst_pulse", bus.press_pulse, 0);
      end
      bus.button1 = 1'b1;
      rst_n = 1'b1;
      step(3);
      chk("rst_rel_led", bus.led, 63);
      chk("rst_rel_pulses", pt_n, 0);

      // clean press
      base = pt_n; c0 = cyc;
      drive(0, 20);
      chk("clean_pulses", pt_n - base, 1);
      chk("clean_lat", pt[base] - c0, 7);
      chk("clean_led", bus.led, 'h3E);
      drive(1, 10);
      chk("clean_rel_pulses", pt_n - base, 1);
      chk("clean_rel_led", bus.led, 'h3E);

      // bouncy press: latency counted from the last falling edge
      base = pt_n;
      drive(0, 1); drive(1, 2); drive(0, 3); drive(1, 1);
      c0 = cyc;
      drive(0, 14);
      chk("bounce_pulses", pt_n - base, 1);
      chk("bounce_lat", pt[base] - c0, 7);
      chk("bounce_led", bus.led, 'h3D);

      // bouncy release
      drive(1, 2); drive(0, 2); drive(1, 1); drive(0, 3); drive(1, 10);
      chk("relbounce_pulses", pt_n - base, 1);
      chk("relbounce_led", bus.led, 'h3D);

      // glitches only
      base = pt_n;
      drive(0, 2); drive(1, 2); drive(0, 3); drive(1, 1); drive(0, 1); drive(1, 10);
      chk("glitch_pulses", pt_n - base, 0);
      chk("glitch_led", bus.led, 'h3D);

      // wrap: 64 presses from zero
      rst_n = 1'b0; step(2);
      chk("wrap_rst_led", bus.led, 63);
      rst_n = 1'b1; step(2);
      base = pt_n;
      for (int i = 1; i <= 64; i++) begin
         drive(0, 8);
         chk("wrap_led", bus.led, (~i) & 63);
         if (i == 63) chk("wrap63_led", bus.led, 0);
         drive(1, 10);
      end
      chk("wrap_pulses", pt_n - base, 64);
      chk("wrap_end_led", bus.led, 63);

      // reset in PRESS_WAIT at counter 2 with the button held
      bus.button1 = 1'b0;
      step(5);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_led", bus.led, 63);
      chk("mid_rst_pulse", bus.press_pulse, 0);
      step(2);
      chk("mid_rst_led2", bus.led, 63);
      base = pt_n; c0 = cyc;
      rst_n = 1'b1;
      step(12);
      chk("mid_pulses", pt_n - base, 1);
      chk("mid_lat", pt[base] - c0, 7);
      chk("mid_led", bus.led, 'h3E);
      drive(1, 10);

      // long hold: repeats when enabled, single event otherwise
      base = pt_n; c0 = cyc;
      drive(0, 63);
      drive(1, 10);
      chk("hold_lat", pt[base] - c0, 7);
`ifdef BUTTON_AUTOREPEAT_EN
      chk("hold_pulses", pt_n - base, 6);
      for (int i = 1; i < 6; i++) chk("hold_off", pt[base + i] - pt[base], rep_off[i]);
      chk("hold_led", bus.led, (~7) & 63);
`else
      chk("hold_pulses", pt_n - base, 1);
      chk("hold_led", bus.led, (~2) & 63);
`endif

      chk("no_back_to_back", dbl, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/button_counter.md
# button_counter

Conditions the raw, bouncy `button1` input of the board and turns each clean press into a one-cycle event that advances a 6-bit press counter shown on `led[5:0]`. It sits between the board pins and the LED bank: the input side synchronises and debounces the button, and the output side drives the active-low LEDs from registered state. It replaces a direct combinational button-to-LED path with a clocked, glitch-free one.

## Interface
- `DEBOUNCE_CYCLES`, default 270000: cycles the synchronised input must be stable before a level change is accepted (10 ms at 27 MHz). Legal values are ≥2.
- `REPEAT_DELAY`, default 13500000: cycles held in PRESSED before the first auto-repeat (500 ms). Used only with `BUTTON_AUTOREPEAT_EN`.
- `REPEAT_PERIOD`, default 2700000: cycles between subsequent auto-repeats (100 ms). Used only with `BUTTON_AUTOREPEAT_EN`.
- `clk` input 1: system clock, 27 MHz. All flops are clocked on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset. Release is synchronous to `clk` externally.
- `button1` input 1: raw button, asynchronous to `clk`. Active-low: 0 = pressed.
- `led` output 6: LED drive, active-low. `led = ~count`.
- `press_pulse` output 1: one-cycle strobe for each accepted press (and each repeat, when enabled).

## Operation
- **Synchroniser:** two flops, `sync1` then `sync0`. Both reset to 1 (released). `btn_s = ~sync0` gives pressed = 1.
- **Debounce counter:** width is ceil(log2(DEBOUNCE_CYCLES)). It clears on every state transition and whenever `btn_s` contradicts the pending level.
- **FSM states:**
  - IDLE: `btn_s`=1 moves to PRESS_WAIT with the counter cleared.
  - PRESS_WAIT: `btn_s`=0 returns to IDLE (bounce). If the counter = DEBOUNCE_CYCLES-1 with `btn_s`=1, move to PRESSED and assert the press event. Otherwise increment.
  - PRESSED: `btn_s`=0 moves to RELEASE_WAIT with the counter cleared.
  - RELEASE_WAIT: `btn_s`=1 returns to PRESSED with no new event. If the counter = DEBOUNCE_CYCLES-1 with `btn_s`=0, move to IDLE. Otherwise increment.
- **Count:** a 6-bit register that increments by 1 on each press event. It wraps from 63 to 0 with no flag.
- **Illegal state encodings** recover to IDLE on the next clock.
- **Reset values:**
  - FSM = IDLE.
  - Counters = 0.
  - `count` = 0, so `led` = 6'b111111 (all off).
  - `press_pulse` = 0.
  - Synchroniser flops = 1.
- **Reset mid-operation** (any state, any counter value) returns everything to the reset values immediately and asynchronously. No event is generated on reset release, even if the button is held; the press must then be debounced from IDLE.

## Timing
- `press_pulse` and `count` are registered on the same edge, the one on which the FSM enters PRESSED. `led` reflects the new `count` in that same cycle.
- **Latency:** `button1` falling (stable) to `press_pulse` high = 2 synchroniser cycles + DEBOUNCE_CYCLES cycles, ±1 cycle of synchroniser sampling.
- `press_pulse` is high for exactly 1 cycle per event. It is never high on two consecutive cycles.
- **Release:** the button must be stable high for DEBOUNCE_CYCLES cycles before the next press can be accepted. Release produces no output change.
- **Bounce:** any opposing sample restarts the debounce window from 0.

## Configuration
- **`BUTTON_AUTOREPEAT_EN` defined:**
  - PRESSED has a repeat timer, cleared on entry to PRESSED.
  - After REPEAT_DELAY cycles in PRESSED, the block emits `press_pulse` and increments `count`.
  - It then repeats every REPEAT_PERIOD cycles while the FSM stays in PRESSED.
  - Entering RELEASE_WAIT freezes the timer. Returning to PRESSED from RELEASE_WAIT resumes it without emitting.
- **Not defined:**
  - Exactly one event per debounced press.
  - The repeat timer and parameters are not synthesised; REPEAT_* values are ignored.

## Test plan
Benches override DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
- **Reset:** hold `rst_n`=0 with the button toggling → `led`=6'b111111 and `press_pulse`=0 throughout. After release, `count`=0.
- **Clean press:** `button1` 1→0, held 20 cycles → exactly one `press_pulse`, arriving 6±1 cycles after the edge. `led` becomes 6'b111110.
- **Bounce rejection:**
  - 0/1 glitches of 1–3 cycles, then stable 0 → a single pulse, counted from the last glitch.
  - Glitches only → no pulse.
  - Release bounce → no extra pulse.
- **Wrap:** 64 clean press/release pairs → `count` returns to 0 and `led`=6'b111111. Press 63 shows `led`=6'b000000.
- **Reset mid-debounce:** assert `rst_n` during PRESS_WAIT at counter 2 while the button is held → state clears. After release with the button still held, the first pulse arrives 4 cycles plus synchroniser latency later, never immediately.
- **Auto-repeat (macro on):** hold the button for 60 cycles after the first event → pulses at +0, +20, +28, +36, +44, +52 relative to entry to PRESSED. With the macro off, the same stimulus gives a single pulse.
